// File: rtl/drum_step_scheduler.sv
// Drum step sequencer: walks STEPS steps per bar on step_tick and fires per-instrument
// triggers. Each instrument has a double-buffered pattern that is swapped in at the start of a bar.
module drum_step_scheduler #(
    parameter int STEPS       = 8,
    parameter int TRIG_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step_tick,
    input  logic             pat_wr,
    input  logic [1:0]       pat_sel,
    input  logic [STEPS-1:0] pat_data,
    input  logic [3:0]       mute,
    output logic [3:0]       trig,
    output logic [3:0]       timing,
    output logic             playing,
    output logic             bar_start,
    output logic             pending
);

    localparam logic [3:0]       LP_LAST = 4'(STEPS);
    localparam logic [3:0]       LP_HOLD = 4'(TRIG_CYCLES);
    localparam logic [STEPS-1:0] LP_ONE  = {{(STEPS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_step;
    logic [3:0]       r_hold [4];
    logic [STEPS-1:0] r_active [4];
    logic [STEPS-1:0] r_shadow [4];
    logic             r_barStart;
    logic             r_pending;

    logic             w_running;
    logic             w_stopNow;
    logic             w_fire;
    logic             w_commit;
    logic [3:0]       w_nextStep;
    logic [3:0]       w_idx;
    logic [STEPS-1:0] w_stepMask;
    logic [3:0]       w_trigNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start && !stop) w_nextState = ARMED;
            ARMED:   if (stop) w_nextState = IDLE;
                     else if (step_tick) w_nextState = RUN;
            RUN:     if (stop) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_running  = (r_state != IDLE);
    assign w_stopNow  = w_running && stop;
    assign w_fire     = w_running && step_tick && !stop;
    assign w_nextStep = ((r_state == ARMED) || (r_step == LP_LAST)) ? 4'd1 : (r_step + 4'd1);
    assign w_commit   = w_fire && (w_nextStep == 4'd1);
    assign w_idx      = w_nextStep - 4'd1;
    assign w_stepMask = LP_ONE << w_idx;

    // A bar-start fire evaluates against the shadow copy, since that copy becomes active on this same edge.
    always_comb begin
        w_trigNext = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (w_commit) w_trigNext[i] = (|(r_shadow[i] & w_stepMask)) && !mute[i];
            else          w_trigNext[i] = (|(r_active[i] & w_stepMask)) && !mute[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step     <= 4'd0;
            r_barStart <= 1'b0;
            for (int i = 0; i < 4; i++) r_hold[i] <= 4'd0;
        end else if (w_stopNow) begin
            r_step     <= 4'd0;
            r_barStart <= 1'b0;
            for (int i = 0; i < 4; i++) r_hold[i] <= 4'd0;
        end else if (w_fire) begin
            r_step     <= w_nextStep;
            r_barStart <= w_commit;
            for (int i = 0; i < 4; i++) r_hold[i] <= w_trigNext[i] ? LP_HOLD : 4'd0;
        end else begin
            r_barStart <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (r_hold[i] != 4'd0) r_hold[i] <= r_hold[i] - 4'd1;
            end
        end
    end

    // The commit copies the old shadow; a write on the same edge lands in shadow and stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_active[i] <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_commit) begin
                for (int i = 0; i < 4; i++) r_active[i] <= r_shadow[i];
            end
            if (pat_wr) begin
                r_shadow[pat_sel] <= pat_data;
                if (r_state == IDLE) r_active[pat_sel] <= pat_data;
            end
            if (pat_wr && (r_state != IDLE)) r_pending <= 1'b1;
            else if (w_commit)               r_pending <= 1'b0;
        end
    end

    always_comb begin
        trig = 4'b0000;
        for (int i = 0; i < 4; i++) trig[i] = (r_hold[i] != 4'd0);
    end

    assign timing    = r_step;
    assign playing   = (r_state == RUN);
    assign bar_start = r_barStart;
    assign pending   = r_pending;

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Bench for drum_step_scheduler: directed scenarios plus random traffic, every cycle scored
// against a bar/step reference model through an expectation queue drained by a monitor.
module tb_drum_step_scheduler;

    localparam int STEPS = 8;
    localparam int TC    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             stepTick;
    logic             patWr;
    logic [1:0]       patSel;
    logic [STEPS-1:0] patData;
    logic [3:0]       mute;
    logic [3:0]       trig;
    logic [3:0]       timing;
    logic             playing;
    logic             barStart;
    logic             pending;

    always #5 clk = ~clk;

    drum_step_scheduler #(.STEPS(STEPS), .TRIG_CYCLES(TC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .step_tick (stepTick),
        .pat_wr    (patWr),
        .pat_sel   (patSel),
        .pat_data  (patData),
        .mute      (mute),
        .trig      (trig),
        .timing    (timing),
        .playing   (playing),
        .bar_start (barStart),
        .pending   (pending)
    );

    typedef struct packed {
        logic [3:0] trig;
        logic [3:0] timing;
        logic       playing;
        logic       barStart;
        logic       pending;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycleNum    = 0;
    bit   monEnable   = 1'b0;

    // Reference model: 0 idle, 1 armed, 2 playing; trig is "last fire's bits, for TC cycles".
    int               mState, mStep, mSince;
    logic             mBar, mPend;
    logic [3:0]       mFire;
    logic [STEPS-1:0] mAct [4];
    logic [STEPS-1:0] mShd [4];

    task automatic modelReset();
        mState = 0; mStep = 0; mSince = TC; mBar = 1'b0; mPend = 1'b0; mFire = 4'b0;
        for (int i = 0; i < 4; i++) begin
            mAct[i] = '0;
            mShd[i] = '0;
        end
    endtask

    task automatic modelEdge();
        int               st0, ns;
        logic [STEPS-1:0] snap [4];
        if (reset) begin
            modelReset();
            return;
        end
        st0 = mState;
        for (int i = 0; i < 4; i++) snap[i] = mShd[i];
        if (st0 != 0 && stop) begin
            mState = 0; mStep = 0; mFire = 4'b0; mBar = 1'b0;
        end else if (st0 != 0 && stepTick) begin
            ns = (st0 == 1 || mStep == STEPS) ? 1 : mStep + 1;
            if (ns == 1) begin
                for (int i = 0; i < 4; i++) mAct[i] = snap[i];
                mPend = 1'b0;
                mBar  = 1'b1;
            end else begin
                mBar = 1'b0;
            end
            for (int i = 0; i < 4; i++)
                mFire[i] = (((mAct[i] >> (ns - 1)) & 1) != 0) && !mute[i];
            mSince = 0; mStep = ns; mState = 2;
        end else begin
            mBar = 1'b0;
            if (mSince < TC) mSince++;
            if (st0 == 0 && start && !stop) mState = 1;
        end
        if (patWr) begin
            mShd[patSel] = patData;
            if (st0 == 0) mAct[patSel] = patData;
            else          mPend = 1'b1;
        end
    endtask

    function automatic exp_t modelOut();
        exp_t e;
        e.trig     = (mSince < TC) ? mFire : 4'b0;
        e.timing   = 4'(mStep);
        e.playing  = (mState == 2);
        e.barStart = mBar;
        e.pending  = mPend;
        return e;
    endfunction

    task automatic checkField(input string name, input int got, input int want);
        testsRun++;
        if (got != want) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycleNum, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t got, input exp_t want);
        checkField({tag, ".trig"},      int'(got.trig),     int'(want.trig));
        checkField({tag, ".timing"},    int'(got.timing),   int'(want.timing));
        checkField({tag, ".playing"},   int'(got.playing),  int'(want.playing));
        checkField({tag, ".bar_start"}, int'(got.barStart), int'(want.barStart));
        checkField({tag, ".pending"},   int'(got.pending),  int'(want.pending));
    endtask

    function automatic exp_t sampleDut();
        exp_t g;
        g.trig = trig; g.timing = timing; g.playing = playing;
        g.barStart = barStart; g.pending = pending;
        return g;
    endfunction

    task automatic applyStimulus(input logic rs, input logic st, input logic sp, input logic tk,
                                 input logic wr, input logic [1:0] sel,
                                 input logic [STEPS-1:0] data, input logic [3:0] mu);
        @(negedge clk);
        reset = rs; start = st; stop = sp; stepTick = tk;
        patWr = wr; patSel = sel; patData = data; mute = mu;
        modelEdge();
        expQ.push_back(modelOut());
        monEnable = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 2'd0, '0, 4'b0);
    endtask

    task automatic tick(input logic [3:0] mu);
        applyStimulus(0, 0, 0, 1, 0, 2'd0, '0, mu);
    endtask

    // Asserts reset between edges and looks at the outputs before any clock edge arrives.
    task automatic asyncResetCheck();
        @(negedge clk);
        reset = 1'b1; start = 0; stop = 0; stepTick = 0; patWr = 0;
        modelEdge();
        expQ.push_back(modelOut());
        #1;
        checkOutput("async_reset", sampleDut(), exp_t'(0));
    endtask

    initial begin : monitor
        exp_t want;
        forever begin
            @(posedge clk);
            #1;
            if (monEnable) begin
                cycleNum++;
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL scoreboard_underflow at cycle %0d: got empty queue expected an entry", cycleNum);
                end else begin
                    want = expQ.pop_front();
                    checkOutput("cycle", sampleDut(), want);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; start = 0; stop = 0; stepTick = 0;
        patWr = 0; patSel = 2'd0; patData = '0; mute = 4'b0;
        modelReset();
        #1;
        checkOutput("power_on_reset", sampleDut(), exp_t'(0));

        applyStimulus(1, 0, 0, 0, 0, 2'd0, '0, 4'b0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, '0, 4'b0);

        // Kick pattern written in idle, then start and first tick fires step 1.
        applyStimulus(0, 0, 0, 0, 1, 2'd1, 8'b0000_0101, 4'b0);
        applyStimulus(0, 1, 0, 0, 0, 2'd0, '0, 4'b0);
        tick(4'b0);
        idle(6);

        // Full bar of snare plus one wrap.
        applyStimulus(0, 0, 1, 0, 0, 2'd0, '0, 4'b0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 8'hFF, 4'b0);
        applyStimulus(0, 1, 0, 0, 0, 2'd0, '0, 4'b0);
        for (int i = 0; i < 9; i++) tick(4'b0);
        idle(2);

        // Hat written mid-bar waits for the next bar.
        tick(4'b0);
        tick(4'b0);
        applyStimulus(0, 0, 0, 0, 1, 2'd2, 8'hFF, 4'b0);
        for (int i = 0; i < 5; i++) begin
            tick(4'b0);
            idle(1);
        end
        tick(4'b0);
        idle(2);

        // Hold restart with snare muted on the second fire.
        tick(4'b0);
        idle(1);
        tick(4'b0001);
        idle(4);

        // Stop wins over a simultaneous tick; start while running is ignored.
        applyStimulus(0, 1, 0, 1, 0, 2'd0, '0, 4'b0);
        applyStimulus(0, 0, 1, 1, 0, 2'd0, '0, 4'b0);
        idle(2);

        // Reset in the middle of a hold, then patterns must be empty.
        applyStimulus(0, 1, 0, 0, 0, 2'd0, '0, 4'b0);
        tick(4'b0);
        idle(1);
        asyncResetCheck();
        applyStimulus(1, 0, 0, 0, 0, 2'd0, '0, 4'b0);
        applyStimulus(0, 1, 0, 0, 0, 2'd0, '0, 4'b0);
        for (int i = 0; i < 4; i++) tick(4'b0);
        idle(3);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic             rs, st, sp, tk, wr;
            logic [1:0]       sel;
            logic [STEPS-1:0] data;
            logic [3:0]       mu;
            rs   = ($urandom_range(0, 299) == 0);
            st   = ($urandom_range(0, 7) == 0);
            sp   = ($urandom_range(0, 39) == 0);
            tk   = ($urandom_range(0, 2) == 0);
            wr   = ($urandom_range(0, 9) == 0);
            sel  = 2'($urandom_range(0, 3));
            data = STEPS'($urandom());
            mu   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            applyStimulus(rs, st, sp, tk, wr, sel, data, mu);
        end

        @(posedge clk);
        #3;
        monEnable = 1'b0;
        checkField("scoreboard_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
